// File: rtl/picoseq_pkg.sv
// Shared definitions for the picoseq micro-sequencer: opcodes, condition selects,
// FSM state encodings and instruction field positions as functions of operand width.
package picoseq_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_WRITE = 3'd1,
    OP_JUMP  = 3'd2,
    OP_CALL  = 3'd3,
    OP_RET   = 3'd4,
    OP_WAIT  = 3'd5,
    OP_DJNZ  = 3'd6,
    OP_HALT  = 3'd7
  } opcode_e;

  localparam logic [3:0] COND_FALSE = 4'd0;
  localparam logic [3:0] COND_TRUE  = 4'd15;

  typedef enum logic {
    ST_FETCH   = 1'b0,
    ST_EXECUTE = 1'b1
  } state_e;

  // Instruction word, MSB first: polarity, cond_sel[4], opcode[3], reg_idx[4], operand.
  function automatic int pol_pos(input int opnd_w);
    return opnd_w + 11;
  endfunction

  function automatic int sel_lsb(input int opnd_w);
    return opnd_w + 7;
  endfunction

  function automatic int op_lsb(input int opnd_w);
    return opnd_w + 4;
  endfunction

  function automatic int idx_lsb(input int opnd_w);
    return opnd_w;
  endfunction

endpackage

// File: rtl/picoseq_cond_sync.sv
// Two-flop synchroniser for the asynchronous condition inputs.
// Latency: 2 clk edges; no backpressure.
module picoseq_cond_sync #(
  parameter int NUM_COND = 6
) (
  input  logic                clk,
  input  logic                res_n,
  input  logic [NUM_COND-1:0] cond,
  output logic [NUM_COND-1:0] cond_s
);

  logic [NUM_COND-1:0] meta;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      meta   <= '0;
      cond_s <= '0;
    end else begin
      meta   <= cond;
      cond_s <= meta;
    end
  end

endmodule

// File: rtl/picoseq.sv
// Tiny ROM-driven sequencer: conditional write/jump/call/ret/wait/djnz/halt on output registers.
// Latency: 2 cycles per instruction (FETCH, EXECUTE); enable=0 stalls in FETCH, no other backpressure.
module picoseq
  import picoseq_pkg::*;
#(
  parameter  int ADDR_W      = 8,
  parameter  int DATA_W      = 8,
  parameter  int NUM_REGS    = 4,
  parameter  int NUM_COND    = 6,
  parameter  int STACK_DEPTH = 4,
  localparam int OPND_W      = (DATA_W > ADDR_W) ? DATA_W : ADDR_W,
  localparam int INSTR_W     = 12 + OPND_W
) (
  input  logic                         clk,
  input  logic                         res_n,
  input  logic                         enable,
  input  logic [NUM_COND-1:0]          cond,
  output logic [ADDR_W-1:0]            rom_addr,
  input  logic [INSTR_W-1:0]           rom_data,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  output logic [NUM_REGS-1:0]          reg_we,
  output logic                         halted,
  output logic                         stack_err
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int SPI_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int P_POL = pol_pos(OPND_W);
  localparam int P_SEL = sel_lsb(OPND_W);
  localparam int P_OP  = op_lsb(OPND_W);
  localparam int P_IDX = idx_lsb(OPND_W);

  state_e              state;
  logic [ADDR_W-1:0]   pc;
  logic [INSTR_W-1:0]  ir;
  logic [DATA_W-1:0]   regs  [2**IDX_W];
  logic [ADDR_W-1:0]   stack [2**SPI_W];
  logic [SP_W-1:0]     sp;
  logic [NUM_COND-1:0] cond_s;

  picoseq_cond_sync #(.NUM_COND(NUM_COND)) u_cond_sync (
    .clk    (clk),
    .res_n  (res_n),
    .cond   (cond),
    .cond_s (cond_s)
  );

  logic              pol;
  logic [3:0]        sel;
  opcode_e           op;
  logic [3:0]        idx;
  logic [OPND_W-1:0] opnd;

  assign pol  = ir[P_POL];
  assign sel  = ir[P_SEL +: 4];
  assign op   = opcode_e'(ir[P_OP +: 3]);
  assign idx  = ir[P_IDX +: 4];
  assign opnd = ir[OPND_W-1:0];

  logic cond_val;
  always_comb begin
    cond_val = 1'b0;
    if (sel == COND_TRUE) cond_val = 1'b1;
    for (int i = 0; i < NUM_COND; i++)
      if (sel == 4'(i + 1)) cond_val = cond_s[i];
  end

  logic                taken, idx_ok, sp_full, sp_empty;
  logic [IDX_W-1:0]    ridx;
  logic [DATA_W-1:0]   cur, dec;
  logic [ADDR_W-1:0]   pc_inc, target;
  logic [SP_W-1:0]     sp_m1;
  logic [NUM_REGS-1:0] we_hot;

  assign taken    = (pol == cond_val);
  assign idx_ok   = ({1'b0, idx} < 5'(NUM_REGS));
  assign ridx     = idx[IDX_W-1:0];
  assign cur      = regs[ridx];
  assign dec      = cur - DATA_W'(1);
  assign pc_inc   = pc + ADDR_W'(1);
  assign target   = opnd[ADDR_W-1:0];
  assign sp_m1    = sp - SP_W'(1);
  assign sp_full  = (sp == SP_W'(STACK_DEPTH));
  assign sp_empty = (sp == '0);
  assign we_hot   = NUM_REGS'(1) << ridx;

  // All architectural state commits on the EXECUTE->FETCH edge only.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state     <= ST_FETCH;
      pc        <= '0;
      ir        <= '0;
      sp        <= '0;
      reg_we    <= '0;
      halted    <= 1'b0;
      stack_err <= 1'b0;
      for (int i = 0; i < 2**IDX_W; i++) regs[i] <= '0;
      for (int i = 0; i < 2**SPI_W; i++) stack[i] <= '0;
    end else begin
      reg_we <= '0;
      case (state)
        ST_FETCH: begin
          if (enable && !halted) begin
            ir    <= rom_data;
            state <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          state <= ST_FETCH;
          pc    <= pc_inc;
          if (taken) begin
            case (op)
              OP_WRITE: begin
                if (idx_ok) begin
                  regs[ridx] <= opnd[DATA_W-1:0];
                  reg_we     <= we_hot;
                end
              end
              OP_JUMP: pc <= target;
              OP_CALL: begin
                if (sp_full) begin
                  stack_err <= 1'b1;
                end else begin
                  stack[sp[SPI_W-1:0]] <= pc_inc;
                  sp                   <= sp + SP_W'(1);
                  pc                   <= target;
                end
              end
              OP_RET: begin
                if (sp_empty) begin
                  stack_err <= 1'b1;
                end else begin
                  pc <= stack[sp_m1[SPI_W-1:0]];
                  sp <= sp_m1;
                end
              end
              OP_DJNZ: begin
                if (idx_ok && cur != '0) begin
                  regs[ridx] <= dec;
                  reg_we     <= we_hot;
                  if (dec != '0) pc <= target;
                end
              end
              OP_HALT: begin
                halted <= 1'b1;
                pc     <= pc;
              end
              default: ;
            endcase
          end else if (op == OP_WAIT) begin
            pc <= pc;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

  assign rom_addr = pc;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regq
    assign reg_q[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule
